// File: rtl/led_mode_sequencer.sv
// Button debounce + blink-mode sequencer driving the blinker enable/rate selects.
// Optional forced-OFF on long hold is enabled by defining LONG_PRESS_OFF_EN.
module led_mode_sequencer #(
  parameter int unsigned c_debounce_count   = 500_000,
  parameter int unsigned c_dwell_count      = 100_000_000,
  parameter int unsigned c_long_press_count = 100_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_button,
  input  logic       i_auto,
  output logic       o_enable,
  output logic       o_select0,
  output logic       o_select1,
  output logic [2:0] o_mode,
  output logic       o_mode_change
);

  typedef enum logic [2:0] {
    OFF  = 3'd0,
    HZ1  = 3'd1,
    HZ5  = 3'd2,
    HZ10 = 3'd3,
    HZ20 = 3'd4
  } mode_t;

  localparam logic [31:0] DB_TC = 32'(c_debounce_count - 1);
  localparam logic [31:0] DW_TC = 32'(c_dwell_count - 1);

  mode_t       mode, mode_nxt;
  logic [1:0]  sel_nxt;
  logic        btn_s1, btn_s2;
  logic        db_level, db_d, press;
  logic [31:0] db_cnt, dwell_cnt;
  logic        auto_step, force_off;

  function automatic mode_t press_next(input mode_t m);
    case (m)
      OFF:     return HZ1;
      HZ1:     return HZ5;
      HZ5:     return HZ10;
      HZ10:    return HZ20;
      default: return OFF;
    endcase
  endfunction

  // Auto-cycle never parks the blinker in OFF.
  function automatic mode_t auto_next(input mode_t m);
    if (m == HZ20 || m == OFF) return HZ1;
    return press_next(m);
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
      db_d     <= 1'b0;
      press    <= 1'b0;
    end else begin
      btn_s1 <= i_button;
      btn_s2 <= btn_s1;
      if (btn_s2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_TC) begin
        db_level <= btn_s2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 32'd1;
      end
      db_d  <= db_level;
      press <= db_level & ~db_d;
    end
  end

`ifdef LONG_PRESS_OFF_EN
  localparam logic [31:0] LP_TC = 32'(c_long_press_count - 1);
  logic [31:0] hold_cnt;
  logic        hold_done;

  // hold_done keeps the forced OFF to a single shot per hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_cnt  <= '0;
      hold_done <= 1'b0;
    end else if (!db_level) begin
      hold_cnt  <= '0;
      hold_done <= 1'b0;
    end else if (!hold_done) begin
      if (hold_cnt == LP_TC) begin
        hold_cnt  <= '0;
        hold_done <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 32'd1;
      end
    end
  end

  assign force_off = db_level && !hold_done && (hold_cnt == LP_TC);
`else
  assign force_off = 1'b0;
`endif

  assign auto_step = i_auto && (dwell_cnt == DW_TC);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      dwell_cnt <= '0;
    else if (press || force_off || auto_step || !i_auto)
      dwell_cnt <= '0;
    else
      dwell_cnt <= dwell_cnt + 32'd1;
  end

  // Press takes priority over a coincident auto step; forced OFF over both.
  always_comb begin
    mode_nxt = mode;
    sel_nxt  = 2'b00;
    if (force_off)      mode_nxt = OFF;
    else if (press)     mode_nxt = press_next(mode);
    else if (auto_step) mode_nxt = auto_next(mode);
    case (mode_nxt)
      HZ5:     sel_nxt = 2'b01;
      HZ10:    sel_nxt = 2'b10;
      HZ20:    sel_nxt = 2'b11;
      default: sel_nxt = 2'b00;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode          <= OFF;
      o_enable      <= 1'b0;
      o_select0     <= 1'b0;
      o_select1     <= 1'b0;
      o_mode_change <= 1'b0;
    end else begin
      mode          <= mode_nxt;
      o_enable      <= (mode_nxt != OFF);
      o_select0     <= sel_nxt[0];
      o_select1     <= sel_nxt[1];
      o_mode_change <= (mode_nxt != mode);
    end
  end

  assign o_mode = mode;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Scoreboard bench for led_mode_sequencer: stimulus queues expected mode updates
// (with the cycle they must appear on), a negedge monitor checks each o_mode_change.
module tb_led_mode_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_button = 1'b0;
  logic       i_auto = 1'b0;
  logic       o_enable, o_select0, o_select1, o_mode_change;
  logic [2:0] o_mode;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0] mode;
    int         cyc;
  } exp_t;
  exp_t q[$];

  led_mode_sequencer #(
    .c_debounce_count  (4),
    .c_dwell_count     (10),
    .c_long_press_count(20)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_button     (i_button),
    .i_auto       (i_auto),
    .o_enable     (o_enable),
    .o_select0    (o_select0),
    .o_select1    (o_select1),
    .o_mode       (o_mode),
    .o_mode_change(o_mode_change)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [1:0] exp_sel(input logic [2:0] m);
    case (m)
      3'd2:    return 2'b01;
      3'd3:    return 2'b10;
      3'd4:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Monitor: every mode-change pulse must match the head of the queue.
  always @(negedge i_clk) begin
    if (!i_rst && o_mode_change) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_change: cyc=%0d mode=%0d, none expected", cyc, o_mode);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (o_mode !== e.mode || o_enable !== (e.mode != 3'd0) ||
            {o_select1, o_select0} !== exp_sel(e.mode) || (e.cyc >= 0 && cyc != e.cyc)) begin
          mismatched++;
          $display("FAIL mode_update: got mode=%0d en=%b sel=%b cyc=%0d, want mode=%0d en=%b sel=%b cyc=%0d",
                   o_mode, o_enable, {o_select1, o_select0}, cyc,
                   e.mode, (e.mode != 3'd0), exp_sel(e.mode), e.cyc);
        end
      end
    end
  end

  task automatic push(input logic [2:0] m, input int c);
    exp_t e;
    e.mode = m;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) tick(1);
  endtask

  task automatic chk_out(input string name, input logic [2:0] m);
    compared++;
    if (o_mode !== m || o_enable !== (m != 3'd0) ||
        {o_select1, o_select0} !== exp_sel(m) || o_mode_change !== 1'b0) begin
      mismatched++;
      $display("FAIL %s: got mode=%0d en=%b sel=%b chg=%b, want mode=%0d en=%b sel=%b chg=0",
               name, o_mode, o_enable, {o_select1, o_select0}, o_mode_change,
               m, (m != 3'd0), exp_sel(m));
    end
  endtask

  // Update lands 8 edges after the raise: 2 sync + 4 debounce + edge detect + mode reg.
  task automatic press(input int hold, input int low, input logic [2:0] m);
    push(m, cyc + 8);
    i_button = 1'b1;
    tick(hold);
    i_button = 1'b0;
    tick(low);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int p;
    tick(1);
    chk_out("in_reset", 3'd0);
    tick(2);
    i_rst = 1'b0;

    // 1. idle after reset
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk_out("idle_after_reset", 3'd0);
    end

    // 2. long press then five short ones
    press(30, 20, 3'd1);
    press(10, 20, 3'd2);
    press(10, 20, 3'd3);
    press(10, 20, 3'd4);
    press(10, 20, 3'd0);
    press(10, 20, 3'd1);

    // 3. glitch shorter than the debounce window
    i_button = 1'b1;
    tick(2);
    i_button = 1'b0;
    tick(20);
    chk_out("after_glitch", 3'd1);

    // 4. auto-cycle from HZ20, including press on the dwell terminal cycle
    press(10, 20, 3'd2);
    press(10, 20, 3'd3);
    press(10, 20, 3'd4);
    k = cyc;
    push(3'd1, k + 10);
    push(3'd2, k + 20);
    push(3'd3, k + 30);
    push(3'd4, k + 40);
    push(3'd1, k + 50);
    push(3'd2, k + 55);
    push(3'd3, k + 65);
    i_auto = 1'b1;
    wait_to(k + 22); i_button = 1'b1;
    wait_to(k + 32); i_button = 1'b0;
    wait_to(k + 47); i_button = 1'b1;
    wait_to(k + 57); i_button = 1'b0;
    wait_to(k + 66); i_auto = 1'b0;
    tick(30);
    chk_out("auto_off_holds", 3'd3);
    k = cyc;
    push(3'd4, k + 10);
    i_auto = 1'b1;
    wait_to(k + 12); i_auto = 1'b0;
    tick(20);

    // 5. reset in the middle of a debounce at HZ10
    press(10, 20, 3'd0);
    press(10, 20, 3'd1);
    press(10, 20, 3'd2);
    press(10, 20, 3'd3);
    i_button = 1'b1;
    tick(4);
    i_rst = 1'b1;
    #1;
    chk_out("async_reset", 3'd0);
    i_button = 1'b0;
    tick(2);
    i_rst = 1'b0;
    tick(30);
    chk_out("no_step_after_reset", 3'd0);

    // 6. long hold from HZ5
    press(10, 20, 3'd1);
    press(10, 20, 3'd2);
    p = cyc;
`ifdef LONG_PRESS_OFF_EN
    press(40, 20, 3'd3);
    push(3'd0, p + 26);
`else
    press(40, 20, 3'd3);
`endif
    tick(20);

    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL missing_updates: %0d expected updates never seen, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
